// File: rtl/cmd_executor.sv
// cmd_executor: fetches 3-bit commands from the upstream command queue one at
// a time, decodes them into sampling-control outputs and, for multi-cycle
// commands, waits for the matching completion pulse (bounded by a timeout)
// before asking the queue for the next command.
module cmd_executor #(
    parameter int                RATE_W         = 4,
    parameter logic [RATE_W-1:0] RATE_INIT      = '0,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter int                RESP_WAIT      = 2
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_enable,
    input  logic              I_cmd_valid,
    input  logic [2:0]        I_cmd_data,
    input  logic              I_done,
    input  logic              I_tx_done,
    output logic              O_exec_req,
    output logic              O_sample_en,
    output logic              O_trig,
    output logic [RATE_W-1:0] O_rate,
    output logic              O_cnt_clr,
    output logic              O_status_req,
    output logic              O_busy,
    output logic              O_timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW_W = $clog2(RESP_WAIT + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RW_W-1:0]   RW_LAST   = RW_W'(RESP_WAIT - 1);
    localparam logic [RATE_W-1:0] RATE_MAX  = {RATE_W{1'b1}};

    typedef enum logic [1:0] {S_REQ, S_WAIT_CMD, S_EXEC, S_WAIT_DONE} state_t;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_START   = 3'd1,
        OP_STOP    = 3'd2,
        OP_SHOT    = 3'd3,
        OP_RATE_UP = 3'd4,
        OP_RATE_DN = 3'd5,
        OP_CLR     = 3'd6,
        OP_STATUS  = 3'd7
    } op_t;

    state_t              state_q,      state_d;
    op_t                 cmd_q,        cmd_d;
    logic [RW_W-1:0]     wait_cnt_q,   wait_cnt_d;
    logic [TO_W-1:0]     to_cnt_q,     to_cnt_d;
    logic                wait_tx_q,    wait_tx_d;    // 1: waiting on I_tx_done, 0: on I_done
    logic                exec_req_q,   exec_req_d;
    logic                sample_en_q,  sample_en_d;
    logic                trig_q,       trig_d;
    logic [RATE_W-1:0]   rate_q,       rate_d;
    logic                cnt_clr_q,    cnt_clr_d;
    logic                status_req_q, status_req_d;
    logic                busy_q,       busy_d;
    logic                timeout_q,    timeout_d;
    logic                done_sel;

    // Only the completion source chosen by the running command is honoured.
    assign done_sel = wait_tx_q ? I_tx_done : I_done;

    // Next-state and registered-output computation for the fetch/execute FSM.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        wait_cnt_d   = wait_cnt_q;
        to_cnt_d     = to_cnt_q;
        wait_tx_d    = wait_tx_q;
        exec_req_d   = 1'b0;
        trig_d       = 1'b0;
        cnt_clr_d    = 1'b0;
        status_req_d = 1'b0;
        sample_en_d  = sample_en_q;
        rate_d       = rate_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_REQ: begin
                if (I_enable) begin
                    exec_req_d = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT_CMD;
                end
            end
            S_WAIT_CMD: begin
                // A request already issued is honoured even if I_enable drops.
                if (I_cmd_valid) begin
                    cmd_d     = op_t'(I_cmd_data);
                    timeout_d = 1'b0;
                    state_d   = S_EXEC;
                end else if (wait_cnt_q == RW_LAST) begin
                    state_d = S_REQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                state_d  = S_REQ;
                to_cnt_d = '0;
                case (cmd_q)
                    OP_START:   sample_en_d = 1'b1;
                    OP_STOP:    sample_en_d = 1'b0;
                    OP_SHOT: begin
                        trig_d    = 1'b1;
                        wait_tx_d = 1'b0;
                        state_d   = S_WAIT_DONE;
                    end
                    OP_RATE_UP: if (rate_q != RATE_MAX) rate_d = rate_q + 1'b1;
                    OP_RATE_DN: if (rate_q != '0)       rate_d = rate_q - 1'b1;
                    OP_CLR:     cnt_clr_d = 1'b1;
                    OP_STATUS: begin
                        status_req_d = 1'b1;
                        wait_tx_d    = 1'b1;
                        state_d      = S_WAIT_DONE;
                    end
                    default: ;
                endcase
            end
            S_WAIT_DONE: begin
                // Done in the expiring cycle wins over the timeout.
                if (done_sel) begin
                    state_d = S_REQ;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase

        busy_d = (state_d == S_EXEC) || (state_d == S_WAIT_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q      <= S_REQ;
            cmd_q        <= OP_NOP;
            wait_cnt_q   <= '0;
            to_cnt_q     <= '0;
            wait_tx_q    <= 1'b0;
            exec_req_q   <= 1'b0;
            sample_en_q  <= 1'b0;
            trig_q       <= 1'b0;
            rate_q       <= RATE_INIT;
            cnt_clr_q    <= 1'b0;
            status_req_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            wait_cnt_q   <= wait_cnt_d;
            to_cnt_q     <= to_cnt_d;
            wait_tx_q    <= wait_tx_d;
            exec_req_q   <= exec_req_d;
            sample_en_q  <= sample_en_d;
            trig_q       <= trig_d;
            rate_q       <= rate_d;
            cnt_clr_q    <= cnt_clr_d;
            status_req_q <= status_req_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign O_exec_req   = exec_req_q;
    assign O_sample_en  = sample_en_q;
    assign O_trig       = trig_q;
    assign O_rate       = rate_q;
    assign O_cnt_clr    = cnt_clr_q;
    assign O_status_req = status_req_q;
    assign O_busy       = busy_q;
    assign O_timeout    = timeout_q;

endmodule
